// File: rtl/act_pack_buf.sv
// Activation packer: assembles PACK_NUM activations into one word and queues words in a small FIFO.
// Optional ACT_PACK_DROP_CNT_EN adds a saturating dropped-word counter output drop_cnt_o.

module act_pack_lane #(
    parameter int ACT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic                clr,
    input  logic [ACT_BITS-1:0] din,
    output logic [ACT_BITS-1:0] nxt
);
    logic [ACT_BITS-1:0] q;

    // nxt includes this cycle's write so a completing lane lands in the committed word
    assign nxt = wr ? din : q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (wr)  q <= din;
    end
endmodule

module act_pack_buf #(
    parameter int ACT_BITS   = 8,
    parameter int PACK_NUM   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ACT_BITS-1:0]          acc_i,
    input  logic                         vld_i,
    input  logic                         flush_i,
    output logic [PACK_NUM*ACT_BITS-1:0] dout_o,
    output logic [PACK_NUM-1:0]          byte_en_o,
    output logic                         vld_o,
    input  logic                         rdy_i,
    output logic                         ovf_o,
`ifdef ACT_PACK_DROP_CNT_EN
    output logic [15:0]                  drop_cnt_o,
`endif
    output logic                         busy_o
);
    localparam int W  = PACK_NUM * ACT_BITS;
    localparam int CW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [W-1:0]        data;
        logic [PACK_NUM-1:0] be;
    } word_t;

    logic [CW-1:0]                          cnt;
    logic [CW:0]                            filled;
    logic [PACK_NUM-1:0][ACT_BITS-1:0]      asm_nxt;
    logic [PACK_NUM-1:0]                    lane_be;
    logic                                   commit, last_lane;
    word_t                                  fifo_mem [FIFO_DEPTH];
    logic [AW:0]                            wr_ptr, rd_ptr;
    logic                                   empty, full, pop, push, drop;

    assign last_lane = vld_i && (cnt == CW'(PACK_NUM - 1));
    assign filled    = {1'b0, cnt} + (CW+1)'(vld_i);
    // A flush with nothing held and no same-cycle byte leaves filled at 0 and does nothing
    assign commit    = last_lane || (flush_i && (filled != '0));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rdy_i;
    assign push  = commit && (!full || pop);
    assign drop  = commit && full && !pop;

    for (genvar k = 0; k < PACK_NUM; k++) begin : g_lane
        act_pack_lane #(.ACT_BITS(ACT_BITS)) u_lane (
            .clk (clk),
            .rst (rst),
            .wr  (vld_i && (cnt == CW'(k))),
            .clr (commit),
            .din (acc_i),
            .nxt (asm_nxt[k])
        );
        assign lane_be[k] = ((CW+1)'(k) < filled);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (commit)     cnt <= '0;
            else if (vld_i) cnt <= cnt + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) ovf_o  <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo_mem[wr_ptr[AW-1:0]] <= '{data: asm_nxt, be: lane_be};
    end

`ifdef ACT_PACK_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              drop_cnt_o <= '0;
        else if (drop && drop_cnt_o != '1)    drop_cnt_o <= drop_cnt_o + 1'b1;
    end
`endif

    assign vld_o     = !empty;
    assign dout_o    = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]].data;
    assign byte_en_o = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]].be;
    assign busy_o    = (cnt != '0) || !empty;
endmodule

// File: tb/tb_act_pack_buf.sv
// Bench for act_pack_buf: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_act_pack_buf;
    localparam int A = 8, P = 16, D = 4, W = P * A;

    logic         clk = 1'b0, rst = 1'b1;
    logic [A-1:0] acc_i = '0;
    logic         vld_i = 1'b0, flush_i = 1'b0, rdy_i = 1'b0;
    logic [W-1:0] dout_o;
    logic [P-1:0] byte_en_o;
    logic         vld_o, ovf_o, busy_o;
`ifdef ACT_PACK_DROP_CNT_EN
    logic [15:0]  drop_cnt_o;
`endif

    act_pack_buf #(.ACT_BITS(A), .PACK_NUM(P), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .acc_i(acc_i), .vld_i(vld_i), .flush_i(flush_i),
        .dout_o(dout_o), .byte_en_o(byte_en_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .ovf_o(ovf_o),
`ifdef ACT_PACK_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [P-1:0] be;
    } word_t;

    typedef struct {
        bit           v;
        logic [A-1:0] a;
        bit           f;
        bit           r;
        bit           ev;
        logic [P-1:0] ebe;
        bit           ebusy;
        logic [39:0]  elo;
    } vec_t;

    word_t        mq[$];
    logic [A-1:0] part [P];
    int           pn = 0;
    bit           m_ovf = 1'b0;
    int           m_drop = 0;
    int           n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: pop the head if ready, append the byte, then emit a word when full or flushed
    task automatic model_tick(input bit v, input logic [A-1:0] a, input bit f, input bit r);
        word_t w;
        if (mq.size() > 0 && r) w = mq.pop_front();
        if (v) begin part[pn] = a; pn++; end
        if (pn == P || (f && pn > 0)) begin
            w.d = '0; w.be = '0;
            for (int k = 0; k < pn; k++) begin
                w.d[k*A +: A] = part[k];
                w.be[k] = 1'b1;
            end
            if (mq.size() < D) mq.push_back(w);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            pn = 0;
        end
    endtask

    task automatic model_check();
        bit ne;
        ne = (mq.size() > 0);
        chk("vld_o", W'(vld_o), W'(ne));
        chk("dout_o", dout_o, ne ? mq[0].d : '0);
        chk("byte_en_o", W'(byte_en_o), ne ? W'(mq[0].be) : '0);
        chk("ovf_o", W'(ovf_o), W'(m_ovf));
        chk("busy_o", W'(busy_o), W'(ne || pn > 0));
`ifdef ACT_PACK_DROP_CNT_EN
        chk("drop_cnt_o", W'(drop_cnt_o), W'(m_drop));
`endif
    endtask

    task automatic step(input bit v, input logic [A-1:0] a, input bit f, input bit r);
        vld_i = v; acc_i = a; flush_i = f; rdy_i = r;
        @(posedge clk);
        model_tick(v, a, f, r);
        #1 model_check();
    endtask

    // Reset is raised between edges with live inputs that must be ignored
    task automatic do_reset();
        rst = 1'b1; vld_i = 1'b1; flush_i = 1'b1; rdy_i = 1'b1; acc_i = 8'hEE;
        #1;
        mq.delete(); pn = 0; m_ovf = 1'b0; m_drop = 0;
        model_check();
        repeat (2) @(posedge clk);
        #1 model_check();
        @(negedge clk);
        rst = 1'b0; vld_i = 1'b0; flush_i = 1'b0; rdy_i = 1'b0;
    endtask

    function automatic logic [W-1:0] seq_word(input int base);
        logic [W-1:0] e;
        for (int k = 0; k < P; k++) e[k*A +: A] = A'(base + k);
        return e;
    endfunction

    initial begin
        vec_t tbl [10];
        tbl[0] = '{1, 8'hA1, 0, 0, 0, 16'h0000, 1, 40'h0};
        tbl[1] = '{1, 8'hA2, 0, 0, 0, 16'h0000, 1, 40'h0};
        tbl[2] = '{1, 8'hA3, 0, 0, 0, 16'h0000, 1, 40'h0};
        tbl[3] = '{1, 8'hA4, 0, 0, 0, 16'h0000, 1, 40'h0};
        tbl[4] = '{1, 8'hA5, 0, 0, 0, 16'h0000, 1, 40'h0};
        tbl[5] = '{0, 8'h00, 1, 0, 1, 16'h001F, 1, 40'hA5A4A3A2A1};
        tbl[6] = '{0, 8'h00, 0, 1, 0, 16'h0000, 0, 40'h0};
        tbl[7] = '{0, 8'h00, 1, 1, 0, 16'h0000, 0, 40'h0};
        tbl[8] = '{1, 8'h77, 1, 0, 1, 16'h0001, 1, 40'h77};
        tbl[9] = '{0, 8'h00, 0, 1, 0, 16'h0000, 0, 40'h0};

        do_reset();

        // Sixteen bytes 0x00..0x0F form one full word
        for (int k = 0; k < 16; k++) step(1'b1, A'(k), 1'b0, 1'b1);
        chk("full word vld", W'(vld_o), W'(1));
        chk("full word dout", dout_o, seq_word(0));
        chk("full word be", W'(byte_en_o), W'(16'hFFFF));
        step(1'b0, '0, 1'b0, 1'b1);

        // Partial flush, empty flush and flush together with the only byte
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].f, tbl[i].r);
            chk($sformatf("tbl%0d vld", i), W'(vld_o), W'(tbl[i].ev));
            chk($sformatf("tbl%0d be", i), W'(byte_en_o), W'(tbl[i].ebe));
            chk($sformatf("tbl%0d busy", i), W'(busy_o), W'(tbl[i].ebusy));
            chk($sformatf("tbl%0d dout", i), dout_o, W'(tbl[i].elo));
        end

        // Five words against a stalled sink: four held, fifth dropped
        do_reset();
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 16; k++) step(1'b1, A'(j*16 + k), 1'b0, 1'b0);
        chk("ovf after drop", W'(ovf_o), W'(1));
`ifdef ACT_PACK_DROP_CNT_EN
        chk("drop count", W'(drop_cnt_o), W'(1));
`endif
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain word%0d", j), dout_o, seq_word(j*16));
            step(1'b0, '0, 1'b0, 1'b1);
        end
        chk("drained vld", W'(vld_o), W'(0));

        // Full FIFO, pop on the completing cycle: no drop
        do_reset();
        for (int k = 0; k < 79; k++) step(1'b1, A'(k), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        chk("push+pop ovf", W'(ovf_o), W'(0));
        chk("push+pop vld", W'(vld_o), W'(1));
        repeat (5) step(1'b0, '0, 1'b0, 1'b1);

        // Flush on the 15th and on the 16th byte
        do_reset();
        for (int k = 0; k < 14; k++) step(1'b1, A'(k), 1'b0, 1'b0);
        step(1'b1, 8'd14, 1'b1, 1'b0);
        chk("flush15 be", W'(byte_en_o), W'(16'h7FFF));
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) step(1'b1, A'(k), 1'b0, 1'b0);
        step(1'b1, 8'd15, 1'b1, 1'b0);
        chk("flush16 be", W'(byte_en_o), W'(16'hFFFF));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush16 single word", W'(vld_o), W'(0));
        chk("flush16 idle busy", W'(busy_o), W'(0));

        // Reset with two words queued and seven bytes pending
        do_reset();
        for (int k = 0; k < 39; k++) step(1'b1, A'(k), 1'b0, 1'b0);
        chk("pre-reset vld", W'(vld_o), W'(1));
        do_reset();
        chk("post-reset vld", W'(vld_o), W'(0));
        chk("post-reset busy", W'(busy_o), W'(0));
        for (int k = 0; k < 16; k++) step(1'b1, A'(8'h40 + k), 1'b0, 1'b0);
        chk("fresh word", dout_o, seq_word(8'h40));
        chk("fresh be", W'(byte_en_o), W'(16'hFFFF));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, A'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
